// File: rtl/regfile_operand_fetch.sv
// regfile_operand_fetch: read-side operand fetch for the 8x16 register file.
// Holds one decoded instruction, drives the file's read selects and output
// enable, tracks pending destination writes in a scoreboard, stalls on
// hazards, and hands captured operands to execute over valid/ready.
//
// Optional build macro: REGFILE_OPFETCH_FORWARD_EN
//   defined   - a same-cycle writeback to a source register is forwarded
//               from wb_data, so that source does not stall.
//   undefined - a same-cycle writeback counts as busy; issue waits a cycle.
//
// state  | meaning
// -------+--------------------------------------------------
// S_IDLE | no held instruction, read port disabled
// S_HOLD | instruction in issue register, read port enabled

module regfile_operand_fetch #(
  parameter int DATA_W = 16,
  parameter int SEL_W  = 3,
  parameter int OPC_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [OPC_W-1:0]     in_opc,
  input  logic [SEL_W-1:0]     in_src1,
  input  logic [SEL_W-1:0]     in_src2,
  input  logic                 in_use1,
  input  logic                 in_use2,
  input  logic [SEL_W-1:0]     in_dst,
  input  logic                 in_wr,
  output logic [SEL_W-1:0]     rf_sel1,
  output logic [SEL_W-1:0]     rf_sel2,
  output logic                 rf_oe,
  input  logic [DATA_W-1:0]    rf_data1,
  input  logic [DATA_W-1:0]    rf_data2,
  input  logic                 wb_en,
  input  logic [SEL_W-1:0]     wb_sel,
  input  logic [DATA_W-1:0]    wb_data,
  output logic                 ex_valid,
  input  logic                 ex_ready,
  output logic [OPC_W-1:0]     ex_opc,
  output logic [DATA_W-1:0]    ex_op1,
  output logic [DATA_W-1:0]    ex_op2,
  output logic [SEL_W-1:0]     ex_dst,
  output logic                 ex_wr,
  output logic [2**SEL_W-1:0]  busy,
  output logic [15:0]          stall_cnt
);

  localparam int NREG = 2**SEL_W;

  typedef enum logic {S_IDLE = 1'b0, S_HOLD = 1'b1} state_t;

  state_t state_q, state_d;

  // issue register
  logic [OPC_W-1:0] h_opc_q, h_opc_d;
  logic [SEL_W-1:0] h_src1_q, h_src1_d;
  logic [SEL_W-1:0] h_src2_q, h_src2_d;
  logic             h_use1_q, h_use1_d;
  logic             h_use2_q, h_use2_d;
  logic [SEL_W-1:0] h_dst_q, h_dst_d;
  logic             h_wr_q, h_wr_d;

  // execute output register
  logic              ex_valid_q, ex_valid_d;
  logic [OPC_W-1:0]  ex_opc_q, ex_opc_d;
  logic [DATA_W-1:0] ex_op1_q, ex_op1_d;
  logic [DATA_W-1:0] ex_op2_q, ex_op2_d;
  logic [SEL_W-1:0]  ex_dst_q, ex_dst_d;
  logic              ex_wr_q, ex_wr_d;

  logic [NREG-1:0] busy_q, busy_d;
  logic [15:0]     stall_cnt_q, stall_cnt_d;

  logic              hold;
  logic              fire;
  logic              issue;
  logic              hazard;
  logic              haz1, haz2, haz_dst;
  logic [NREG-1:0]   wb_vec;
  logic [NREG-1:0]   busy_now;
  logic [DATA_W-1:0] op1, op2;

  // Writeback in flight this cycle has not reached the file yet, so it is
  // treated as still pending for hazard purposes.
  always_comb begin
    wb_vec   = wb_en ? (NREG'(1) << wb_sel) : '0;
    busy_now = busy_q | wb_vec;
  end

`ifdef REGFILE_OPFETCH_FORWARD_EN
  logic fwd1, fwd2;

  // Source hazards resolved by bypassing the writeback bus.
  always_comb begin
    fwd1    = h_use1_q & wb_en & (wb_sel == h_src1_q);
    fwd2    = h_use2_q & wb_en & (wb_sel == h_src2_q);
    haz1    = h_use1_q & busy_q[h_src1_q] & ~fwd1;
    haz2    = h_use2_q & busy_q[h_src2_q] & ~fwd2;
    op1     = fwd1 ? wb_data : rf_data1;
    op2     = fwd2 ? wb_data : rf_data2;
  end
`else
  // Source hazards including the same-cycle writeback.
  always_comb begin
    haz1    = h_use1_q & busy_now[h_src1_q];
    haz2    = h_use2_q & busy_now[h_src2_q];
    op1     = rf_data1;
    op2     = rf_data2;
  end
`endif

  // Issue/accept decision for the held instruction.
  always_comb begin
    hold    = (state_q == S_HOLD);
    haz_dst = h_wr_q & busy_now[h_dst_q];
    hazard  = hold & (haz1 | haz2 | haz_dst);
    issue   = hold & ~hazard & (~ex_valid_q | ex_ready);
    fire    = in_valid & in_ready;
  end

  // State register and all datapath flops.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      h_opc_q     <= '0;
      h_src1_q    <= '0;
      h_src2_q    <= '0;
      h_use1_q    <= 1'b0;
      h_use2_q    <= 1'b0;
      h_dst_q     <= '0;
      h_wr_q      <= 1'b0;
      ex_valid_q  <= 1'b0;
      ex_opc_q    <= '0;
      ex_op1_q    <= '0;
      ex_op2_q    <= '0;
      ex_dst_q    <= '0;
      ex_wr_q     <= 1'b0;
      busy_q      <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      h_opc_q     <= h_opc_d;
      h_src1_q    <= h_src1_d;
      h_src2_q    <= h_src2_d;
      h_use1_q    <= h_use1_d;
      h_use2_q    <= h_use2_d;
      h_dst_q     <= h_dst_d;
      h_wr_q      <= h_wr_d;
      ex_valid_q  <= ex_valid_d;
      ex_opc_q    <= ex_opc_d;
      ex_op1_q    <= ex_op1_d;
      ex_op2_q    <= ex_op2_d;
      ex_dst_q    <= ex_dst_d;
      ex_wr_q     <= ex_wr_d;
      busy_q      <= busy_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (fire) state_d = S_HOLD;
      S_HOLD:  if (issue) state_d = fire ? S_HOLD : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs: accept handshake and register-file read enable.
  always_comb begin
    in_ready = (state_q == S_IDLE) | issue;
    rf_oe    = (state_q == S_HOLD);
  end

  // Issue register, execute register, scoreboard and stall counter updates.
  always_comb begin
    h_opc_d  = h_opc_q;
    h_src1_d = h_src1_q;
    h_src2_d = h_src2_q;
    h_use1_d = h_use1_q;
    h_use2_d = h_use2_q;
    h_dst_d  = h_dst_q;
    h_wr_d   = h_wr_q;
    if (fire) begin
      h_opc_d  = in_opc;
      h_src1_d = in_src1;
      h_src2_d = in_src2;
      h_use1_d = in_use1;
      h_use2_d = in_use2;
      h_dst_d  = in_dst;
      h_wr_d   = in_wr;
    end

    ex_valid_d = ex_valid_q & ~ex_ready;
    ex_opc_d   = ex_opc_q;
    ex_op1_d   = ex_op1_q;
    ex_op2_d   = ex_op2_q;
    ex_dst_d   = ex_dst_q;
    ex_wr_d    = ex_wr_q;
    if (issue) begin
      ex_valid_d = 1'b1;
      ex_opc_d   = h_opc_q;
      ex_op1_d   = h_use1_q ? op1 : '0;
      ex_op2_d   = h_use2_q ? op2 : '0;
      ex_dst_d   = h_dst_q;
      ex_wr_d    = h_wr_q;
    end

    // Clear first, then set, so a newly issued write stays pending.
    busy_d = busy_q & ~wb_vec;
    if (issue && h_wr_q) busy_d[h_dst_q] = 1'b1;

    stall_cnt_d = stall_cnt_q;
    if (hazard && (stall_cnt_q != 16'hFFFF)) stall_cnt_d = stall_cnt_q + 16'd1;
  end

  assign rf_sel1   = h_src1_q;
  assign rf_sel2   = h_src2_q;
  assign ex_valid  = ex_valid_q;
  assign ex_opc    = ex_opc_q;
  assign ex_op1    = ex_op1_q;
  assign ex_op2    = ex_op2_q;
  assign ex_dst    = ex_dst_q;
  assign ex_wr     = ex_wr_q;
  assign busy      = busy_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_regfile_operand_fetch.sv
// Directed bench for regfile_operand_fetch with a behavioural 8x16 register
// file on the writeback bus. Expectations follow the build macro
// REGFILE_OPFETCH_FORWARD_EN where forwarding changes timing.

module tb_regfile_operand_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_opc;
  logic [2:0]  in_src1, in_src2;
  logic        in_use1, in_use2;
  logic [2:0]  in_dst;
  logic        in_wr;
  logic [2:0]  rf_sel1, rf_sel2;
  logic        rf_oe;
  logic [15:0] rf_data1, rf_data2;
  logic        wb_en;
  logic [2:0]  wb_sel;
  logic [15:0] wb_data;
  logic        ex_valid;
  logic        ex_ready;
  logic [7:0]  ex_opc;
  logic [15:0] ex_op1, ex_op2;
  logic [2:0]  ex_dst;
  logic        ex_wr;
  logic [7:0]  busy;
  logic [15:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  logic [15:0] rf_mem [8];
  logic [15:0] s0;

  always #5 clk = ~clk;

  // Register file model; the undriven read bus shows a recognisable junk value.
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) rf_mem[i] <= 16'h0000;
    end else if (wb_en) begin
      rf_mem[wb_sel] <= wb_data;
    end
  end
  assign rf_data1 = rf_oe ? rf_mem[rf_sel1] : 16'hDEAD;
  assign rf_data2 = rf_oe ? rf_mem[rf_sel2] : 16'hDEAD;

  regfile_operand_fetch #(.DATA_W(16), .SEL_W(3), .OPC_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_opc(in_opc),
    .in_src1(in_src1), .in_src2(in_src2), .in_use1(in_use1), .in_use2(in_use2),
    .in_dst(in_dst), .in_wr(in_wr),
    .rf_sel1(rf_sel1), .rf_sel2(rf_sel2), .rf_oe(rf_oe),
    .rf_data1(rf_data1), .rf_data2(rf_data2),
    .wb_en(wb_en), .wb_sel(wb_sel), .wb_data(wb_data),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_opc(ex_opc),
    .ex_op1(ex_op1), .ex_op2(ex_op2), .ex_dst(ex_dst), .ex_wr(ex_wr),
    .busy(busy), .stall_cnt(stall_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_in(input logic v, input logic [7:0] opc,
                          input logic [2:0] s1, input logic [2:0] s2,
                          input logic u1, input logic u2,
                          input logic [2:0] d, input logic w);
    in_valid = v; in_opc = opc; in_src1 = s1; in_src2 = s2;
    in_use1 = u1; in_use2 = u2; in_dst = d; in_wr = w;
  endtask

  task automatic drive_wb(input logic en, input logic [2:0] sel, input logic [15:0] data);
    wb_en = en; wb_sel = sel; wb_data = data;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ex_ready = 1'b1;
    drive_in(1'b0, 8'h00, 3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0);
    drive_wb(1'b0, 3'd0, 16'h0000);
    repeat (3) tick();
    rst_n = 1'b1;
    #1;
    checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL reset_ex_valid got %h exp 0", ex_valid); end
    checks++; if (busy !== 8'h00) begin errors++; $display("FAIL reset_busy got %h exp 00", busy); end
    checks++; if (stall_cnt !== 16'h0000) begin errors++; $display("FAIL reset_stall got %h exp 0000", stall_cnt); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %h exp 1", in_ready); end
    checks++; if (rf_oe !== 1'b0) begin errors++; $display("FAIL reset_rf_oe got %h exp 0", rf_oe); end
    checks++; if ({ex_opc, ex_op1, ex_op2, ex_dst, ex_wr} !== 44'h0) begin errors++; $display("FAIL reset_ex_fields got %h exp 0", {ex_opc, ex_op1, ex_op2, ex_dst, ex_wr}); end
  endtask

  task automatic test_preload();
    drive_wb(1'b1, 3'd1, 16'h1234); tick();
    drive_wb(1'b1, 3'd2, 16'h00FF); tick();
    drive_wb(1'b0, 3'd0, 16'h0000);
    checks++; if (busy !== 8'h00) begin errors++; $display("FAIL preload_busy got %h exp 00", busy); end
  endtask

  task automatic test_basic_issue();
    ex_ready = 1'b1;
    drive_in(1'b1, 8'hA5, 3'd1, 3'd2, 1'b1, 1'b1, 3'd0, 1'b0);
    tick();
    drive_in(1'b0, 8'h00, 3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0);
    checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL basic_lat1_valid got %h exp 0", ex_valid); end
    checks++; if (rf_oe !== 1'b1 || rf_sel1 !== 3'd1 || rf_sel2 !== 3'd2) begin errors++; $display("FAIL basic_rf_ctrl got oe=%h s1=%h s2=%h exp oe=1 s1=1 s2=2", rf_oe, rf_sel1, rf_sel2); end
    tick();
    checks++; if (ex_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %h exp 1", ex_valid); end
    checks++; if (ex_op1 !== 16'h1234) begin errors++; $display("FAIL basic_op1 got %h exp 1234", ex_op1); end
    checks++; if (ex_op2 !== 16'h00FF) begin errors++; $display("FAIL basic_op2 got %h exp 00ff", ex_op2); end
    checks++; if (ex_opc !== 8'hA5 || ex_wr !== 1'b0) begin errors++; $display("FAIL basic_opc got %h/%h exp a5/0", ex_opc, ex_wr); end
    checks++; if (busy !== 8'h00 || stall_cnt !== 16'h0) begin errors++; $display("FAIL basic_busy_stall got %h/%h exp 00/0000", busy, stall_cnt); end
    tick();
    checks++; if (ex_valid !== 1'b0 || rf_oe !== 1'b0) begin errors++; $display("FAIL basic_drain got v=%h oe=%h exp 0/0", ex_valid, rf_oe); end
  endtask

  task automatic test_backpressure();
    ex_ready = 1'b0;
    drive_in(1'b1, 8'h11, 3'd1, 3'd0, 1'b1, 1'b0, 3'd0, 1'b0);
    tick();
    drive_in(1'b1, 8'h22, 3'd0, 3'd2, 1'b0, 1'b1, 3'd0, 1'b0);
    tick();
    drive_in(1'b0, 8'h00, 3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0);
    s0 = stall_cnt;
    checks++; if (ex_valid !== 1'b1 || ex_opc !== 8'h11 || ex_op1 !== 16'h1234 || ex_op2 !== 16'h0) begin errors++; $display("FAIL bp_first got v=%h opc=%h op1=%h op2=%h exp 1/11/1234/0000", ex_valid, ex_opc, ex_op1, ex_op2); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready cyc%0d got %h exp 0", i, in_ready); end
      tick();
      checks++; if (ex_valid !== 1'b1 || ex_opc !== 8'h11 || ex_op1 !== 16'h1234) begin errors++; $display("FAIL bp_stable cyc%0d got v=%h opc=%h op1=%h exp 1/11/1234", i, ex_valid, ex_opc, ex_op1); end
      checks++; if (stall_cnt !== s0) begin errors++; $display("FAIL bp_stall cyc%0d got %h exp %h", i, stall_cnt, s0); end
    end
    ex_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got %h exp 1", in_ready); end
    tick();
    checks++; if (ex_valid !== 1'b1 || ex_opc !== 8'h22 || ex_op1 !== 16'h0 || ex_op2 !== 16'h00FF) begin errors++; $display("FAIL bp_second got v=%h opc=%h op1=%h op2=%h exp 1/22/0000/00ff", ex_valid, ex_opc, ex_op1, ex_op2); end
    tick();
    checks++; if (ex_valid !== 1'b0 || rf_oe !== 1'b0 || rf_sel2 !== 3'd2) begin errors++; $display("FAIL bp_idle got v=%h oe=%h sel2=%h exp 0/0/2", ex_valid, rf_oe, rf_sel2); end
  endtask

  task automatic test_raw_stall();
    ex_ready = 1'b1;
    drive_in(1'b1, 8'h01, 3'd0, 3'd0, 1'b0, 1'b0, 3'd3, 1'b1);
    tick();
    drive_in(1'b1, 8'h02, 3'd3, 3'd0, 1'b1, 1'b0, 3'd0, 1'b0);
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL raw_b2b_ready got %h exp 1", in_ready); end
    tick();
    drive_in(1'b0, 8'h00, 3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0);
    checks++; if (busy !== 8'h08 || ex_dst !== 3'd3 || ex_wr !== 1'b1) begin errors++; $display("FAIL raw_i0_issue got busy=%h dst=%h wr=%h exp 08/3/1", busy, ex_dst, ex_wr); end
    repeat (4) tick();
    checks++; if (stall_cnt !== 16'd4 || ex_valid !== 1'b0) begin errors++; $display("FAIL raw_stalled got stall=%h v=%h exp 0004/0", stall_cnt, ex_valid); end
    drive_wb(1'b1, 3'd3, 16'hBEEF);
    tick();
    drive_wb(1'b0, 3'd0, 16'h0000);
`ifdef REGFILE_OPFETCH_FORWARD_EN
    checks++; if (ex_valid !== 1'b1 || ex_op1 !== 16'hBEEF || ex_opc !== 8'h02) begin errors++; $display("FAIL raw_fwd_issue got v=%h op1=%h opc=%h exp 1/beef/02", ex_valid, ex_op1, ex_opc); end
    checks++; if (stall_cnt !== 16'd4 || busy !== 8'h00) begin errors++; $display("FAIL raw_fwd_stall got stall=%h busy=%h exp 0004/00", stall_cnt, busy); end
`else
    checks++; if (ex_valid !== 1'b0 || busy !== 8'h00) begin errors++; $display("FAIL raw_wb_cycle got v=%h busy=%h exp 0/00", ex_valid, busy); end
    tick();
    checks++; if (ex_valid !== 1'b1 || ex_op1 !== 16'hBEEF || ex_opc !== 8'h02) begin errors++; $display("FAIL raw_issue got v=%h op1=%h opc=%h exp 1/beef/02", ex_valid, ex_op1, ex_opc); end
    checks++; if (stall_cnt !== 16'd5) begin errors++; $display("FAIL raw_stall got %h exp 0005", stall_cnt); end
`endif
    tick();
  endtask

  task automatic test_waw_set_clear();
    ex_ready = 1'b1;
    s0 = stall_cnt;
    drive_in(1'b1, 8'h30, 3'd0, 3'd0, 1'b0, 1'b0, 3'd5, 1'b1);
    tick();
    drive_in(1'b1, 8'h33, 3'd7, 3'd7, 1'b0, 1'b0, 3'd5, 1'b1);
    tick();
    drive_in(1'b0, 8'h00, 3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0);
    checks++; if (busy !== 8'h20) begin errors++; $display("FAIL waw_busy5 got %h exp 20", busy); end
    tick();
    drive_wb(1'b1, 3'd5, 16'h5555);
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL waw_wb_cycle_ready got %h exp 0", in_ready); end
    tick();
    drive_wb(1'b0, 3'd0, 16'h0000);
    checks++; if (busy !== 8'h00 || ex_valid !== 1'b0 || stall_cnt !== s0 + 16'd2) begin errors++; $display("FAIL waw_cleared got busy=%h v=%h stall=%h exp 00/0/%h", busy, ex_valid, stall_cnt, s0 + 16'd2); end
    tick();
    checks++; if (ex_valid !== 1'b1 || ex_opc !== 8'h33 || ex_dst !== 3'd5 || busy !== 8'h20) begin errors++; $display("FAIL waw_issue got v=%h opc=%h dst=%h busy=%h exp 1/33/5/20", ex_valid, ex_opc, ex_dst, busy); end
    drive_wb(1'b1, 3'd1, 16'h1234);
    tick();
    checks++; if (busy !== 8'h20) begin errors++; $display("FAIL wb_nonbusy got %h exp 20", busy); end
    drive_wb(1'b1, 3'd5, 16'h6666);
    tick();
    drive_wb(1'b0, 3'd0, 16'h0000);
    checks++; if (busy !== 8'h00) begin errors++; $display("FAIL waw_final_clear got %h exp 00", busy); end
  endtask

  task automatic test_reset_mid();
    ex_ready = 1'b0;
    drive_in(1'b1, 8'h40, 3'd0, 3'd0, 1'b0, 1'b0, 3'd4, 1'b1);
    tick();
    drive_in(1'b1, 8'h41, 3'd4, 3'd0, 1'b1, 1'b0, 3'd0, 1'b0);
    tick();
    drive_in(1'b0, 8'h00, 3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0);
    tick();
    checks++; if (ex_valid !== 1'b1 || busy !== 8'h10 || rf_oe !== 1'b1 || stall_cnt === 16'h0) begin errors++; $display("FAIL mid_setup got v=%h busy=%h oe=%h stall=%h exp 1/10/1/nonzero", ex_valid, busy, rf_oe, stall_cnt); end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    ex_ready = 1'b1;
    #1;
    checks++; if (ex_valid !== 1'b0 || busy !== 8'h00 || in_ready !== 1'b1 || rf_oe !== 1'b0 || stall_cnt !== 16'h0) begin errors++; $display("FAIL mid_reset got v=%h busy=%h rdy=%h oe=%h stall=%h exp 0/00/1/0/0000", ex_valid, busy, in_ready, rf_oe, stall_cnt); end
    tick();
    checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL mid_no_issue got %h exp 0", ex_valid); end
  endtask

  task automatic test_saturation();
    ex_ready = 1'b1;
    drive_in(1'b1, 8'h60, 3'd0, 3'd0, 1'b0, 1'b0, 3'd6, 1'b1);
    tick();
    drive_in(1'b1, 8'h61, 3'd6, 3'd0, 1'b1, 1'b0, 3'd0, 1'b0);
    tick();
    drive_in(1'b0, 8'h00, 3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0);
    repeat (70000) tick();
    checks++; if (stall_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_value got %h exp ffff", stall_cnt); end
    repeat (5) tick();
    checks++; if (stall_cnt !== 16'hFFFF || ex_valid !== 1'b0 || rf_oe !== 1'b1) begin errors++; $display("FAIL sat_hold got stall=%h v=%h oe=%h exp ffff/0/1", stall_cnt, ex_valid, rf_oe); end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_preload();
    test_basic_issue();
    test_backpressure();
    test_raw_stall();
    test_waw_set_clear();
    test_reset_mid();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_operand_fetch.md
Name: regfile_operand_fetch

Overview:
- Read-side companion to the 8x16 CPU register file (one write port, two read ports, shared output enable).
- Accepts decoded instructions from the decoder, drives the register file's two read selects and output enable, and tracks pending destination writes in an 8-bit scoreboard.
- Stalls on hazards; captures both operands into an output register handed to execute over a valid/ready handshake.
- Watches the writeback port, the same write bus that drives the register file, to retire pending writes.

Parameters:
- DATA_W, 16, operand/register width
- SEL_W, 3, register select width (2**SEL_W registers)
- OPC_W, 8, opaque opcode width carried through to execute

Ports:
- clk  input  1  clock, all state updates on posedge
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  decoder has an instruction
- in_ready  output  1  block accepts the instruction this cycle
- in_opc  input  OPC_W  opcode, passed through
- in_src1, in_src2  input  SEL_W  source register selects
- in_use1, in_use2  input  1  source is actually read
- in_dst  input  SEL_W  destination register
- in_wr  input  1  instruction writes in_dst
- rf_sel1, rf_sel2  output  SEL_W  to register file read selects
- rf_oe  output  1  to register file output enable
- rf_data1, rf_data2  input  DATA_W  from register file read ports (high-Z when rf_oe=0)
- wb_en  input  1  writeback strobe (register file write_enable)
- wb_sel  input  SEL_W  writeback register (register file sel_in)
- wb_data  input  DATA_W  writeback data (register file data_in)
- ex_valid  output  1  operands valid to execute
- ex_ready  input  1  execute accepts
- ex_opc  output  OPC_W  registered opcode
- ex_op1, ex_op2  output  DATA_W  registered operands (0 for unused source)
- ex_dst  output  SEL_W  registered destination
- ex_wr  output  1  registered write flag
- busy  output  2**SEL_W  scoreboard, bit n = write to Rn pending
- stall_cnt  output  16  saturating count of hazard-stall cycles

Behaviour:
- Reset (rst_n=0 at posedge): state IDLE, busy=0, ex_valid=0, ex_opc/ex_op1/ex_op2/ex_dst/ex_wr=0, stall_cnt=0, held instruction discarded. Reset mid-stall or with ex_valid=1 drops everything; no issue follows.
- States:
  - IDLE: no held instruction.
  - HOLD: instruction latched in an internal issue register.
- Accept: in_ready=1 in IDLE, or in HOLD on a cycle that issues. A fire (in_valid & in_ready) latches the instruction → HOLD.
- HOLD, every cycle:
  - rf_oe=1; rf_sel1/rf_sel2 = held src1/src2.
  - rf_oe=0 in IDLE; rf_sel holds its last value.
- Hazard, all terms using the current-cycle busy register:
  - (use1 & busy[src1]) | (use2 & busy[src2]) | (wr & busy[dst]).
  - A register is also treated as busy when wb_en & wb_sel equals it in this same cycle: the file write has not landed, so the read returns stale data.
- Issue condition: HOLD & !hazard & (!ex_valid | ex_ready). On the issue edge:
  - ex_* loads the held fields; ex_op = rf_data when that source is used, else 0; ex_valid=1.
  - If wr, busy[dst] is set.
  - Next state: HOLD if a new instruction fires the same cycle, else IDLE.
- Back-to-back throughput is 1 instruction/cycle. Minimum latency from in fire to ex_valid is 2 cycles.
- ex_valid clears on ex_ready when no issue happens that cycle. ex_* holds stable while ex_valid & !ex_ready.
- Scoreboard: wb_en clears busy[wb_sel]. If the same register is set and cleared in the same cycle, set wins (the newer write is pending). wb_en to a non-busy register only writes the file; busy is unchanged.
- stall_cnt increments each HOLD cycle that has a hazard; saturates at 0xFFFF. Output backpressure alone does not count.
- Selects of all-ones (R7) and zero (R0) are ordinary registers; no hardwired zero.

Optional Feature:
- Macro: REGFILE_OPFETCH_FORWARD_EN.
- Defined: a source hazard is suppressed when wb_en & wb_sel equals that source this cycle. The operand is taken from wb_data instead of rf_data, and issue may happen that cycle. WAW (dst) hazard rules are unchanged.
- Undefined: same-cycle writeback counts as busy; issue occurs no earlier than the cycle after wb_en.

Test Plan:
- Reset then idle: R1=0x1234, R2=0x00FF preloaded. Issue src1=1, src2=2, use both, wr=0, ex_ready=1 → ex_valid 2 cycles after fire, ex_op1=0x1234, ex_op2=0x00FF, busy=0, stall_cnt=0.
- RAW stall: issue I0 wr dst=3, then I1 src1=3 back-to-back; hold wb off 4 cycles, then wb_en sel=3 data=0xBEEF → I1 issues the cycle after wb without FORWARD_EN (ex_op1=0xBEEF, stall_cnt=5), or in the wb cycle with it (stall_cnt=4).
- Backpressure: ex_ready=0 for 3 cycles with ex_valid=1 → ex_* stable, in_ready=0 after one held instruction, stall_cnt unchanged; ex_ready=1 → next issue immediately.
- Same-cycle set/clear: busy[5]=1, issue wr dst=5 while wb_en sel=5 → stalls on WAW until that wb, then issues; after the issue edge busy[5]=1.
- Reset mid-operation: rst_n=0 while HOLD with a hazard and ex_valid=1 → next cycle ex_valid=0, busy=0, in_ready=1, rf_oe=0, stall_cnt=0.
- Saturation: force 70000 hazard cycles → stall_cnt=0xFFFF and holds.
